// File: rtl/decode_buffer.sv
// decode_buffer: circular FIFO between fetch and issue that stores raw
// instructions with their PC and presents the head entry fully decoded.
// Optional feature: define DECODE_BUFFER_BYPASS_EN for zero-latency
// pass-through of an offered instruction when the buffer is empty.
// Instruction layout (INST_LEN=28): [27:24] opcode, [23:20] rd,
// [19:16] rs2, [15:0] rs1 / immediate.

`ifndef INST_LEN
`define INST_LEN 28
`endif
`ifndef INST_SIZE_LOG
`define INST_SIZE_LOG 4
`endif
`ifndef MEMI_SIZE_LOG
`define MEMI_SIZE_LOG 8
`endif
`ifndef REG_LEN
`define REG_LEN 16
`endif
`ifndef RF_SIZE_LOG
`define RF_SIZE_LOG 4
`endif
`ifndef OPCODE
`define OPCODE 27:24
`endif
`ifndef RD
`define RD 23:20
`endif
`ifndef RS2
`define RS2 19:16
`endif
`ifndef RS1
`define RS1 15:0
`endif
`ifndef OP_LI
`define OP_LI  4'd1
`endif
`ifndef OP_ADD
`define OP_ADD 4'd2
`endif
`ifndef OP_MUL
`define OP_MUL 4'd3
`endif
`ifndef OP_LD
`define OP_LD  4'd4
`endif
`ifndef OP_BR
`define OP_BR  4'd5
`endif

module decode_buffer #(
    parameter int DEPTH      = 4,
    parameter bit STOP_AT_BR = 1'b0,
    parameter int PTR_W      = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [`INST_LEN-1:0]      in_inst,
    input  logic [`MEMI_SIZE_LOG-1:0] in_pc,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [`MEMI_SIZE_LOG-1:0] out_pc,
    output logic [`INST_SIZE_LOG-1:0] out_opcode,
    output logic                      out_rs1_used,
    output logic                      out_rs2_used,
    output logic                      out_wen,
    output logic                      out_rd_data_use_alu,
    output logic                      out_mem_valid,
    output logic                      out_is_br,
    output logic [`REG_LEN-1:0]       out_rs1_imm,
    output logic [`MEMI_SIZE_LOG-1:0] out_rs1_br_offset,
    output logic [`RF_SIZE_LOG-1:0]   out_rs1,
    output logic [`RF_SIZE_LOG-1:0]   out_rs2,
    output logic [`RF_SIZE_LOG-1:0]   out_rd,
    output logic [PTR_W:0]            count
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        logic rs1_used;
        logic rs2_used;
        logic wen;
        logic alu;
        logic mem;
        logic br;
    } flags_t;

    function automatic flags_t decode_flags(input logic [`INST_SIZE_LOG-1:0] op);
        flags_t f;
        f = '0;
        case (op)
            `OP_LI:  begin f.wen = 1'b1; f.alu = 1'b1; end
            `OP_ADD,
            `OP_MUL: begin f.rs1_used = 1'b1; f.rs2_used = 1'b1; f.wen = 1'b1; f.alu = 1'b1; end
            `OP_LD:  begin f.rs1_used = 1'b1; f.wen = 1'b1; f.mem = 1'b1; end
            `OP_BR:  begin f.rs2_used = 1'b1; f.br = 1'b1; end
            default: f = '0;
        endcase
        return f;
    endfunction

    logic [`INST_LEN-1:0]      inst_mem_q [DEPTH];
    logic [`MEMI_SIZE_LOG-1:0] pc_mem_q   [DEPTH];
    logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]            count_q, count_d;
    logic                      br_pending_q, br_pending_d;
    logic                      bypass, wr_en, rd_en, in_is_br;
    logic [`INST_LEN-1:0]      head_inst;
    flags_t                    head_flags;

    // Handshakes, head selection (storage or bypass) and decode of the head
    always_comb begin
        bypass = 1'b0;
`ifdef DECODE_BUFFER_BYPASS_EN
        bypass = (count_q == '0) && !flush && in_valid;
`endif
        in_ready  = !rst && !flush && (count_q < FULL_CNT) && !br_pending_q;
        out_valid = !flush && ((count_q != '0) || bypass);
        // A bypassed instruction that is consumed immediately is never stored
        wr_en     = in_valid && in_ready && !(bypass && out_ready);
        rd_en     = out_valid && out_ready && !bypass;
        in_is_br  = (in_inst[`OPCODE] == `OP_BR);

        head_inst  = bypass ? in_inst : inst_mem_q[head_q];
        out_pc     = bypass ? in_pc   : pc_mem_q[head_q];
        head_flags = decode_flags(head_inst[`OPCODE]);

        out_opcode          = head_inst[`OPCODE];
        out_rs1_used        = head_flags.rs1_used;
        out_rs2_used        = head_flags.rs2_used;
        out_wen             = head_flags.wen;
        out_rd_data_use_alu = head_flags.alu;
        out_mem_valid       = head_flags.mem;
        out_is_br           = head_flags.br;
        out_rs1_imm         = head_inst[`RS1];
        out_rs1_br_offset   = out_rs1_imm[`MEMI_SIZE_LOG-1:0];
        out_rs1             = out_rs1_imm[`RF_SIZE_LOG-1:0];
        out_rs2             = head_inst[`RS2];
        out_rd              = head_inst[`RD];
        count               = count_q;
    end

    // Next-state for pointers, occupancy and the branch-serialising flag
    always_comb begin
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        br_pending_d = br_pending_q;
        if (flush) begin
            head_d       = '0;
            tail_d       = '0;
            count_d      = '0;
            br_pending_d = 1'b0;
        end else begin
            if (wr_en) tail_d = tail_q + 1'b1;
            if (rd_en) head_d = head_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (STOP_AT_BR) begin
                // Clear first so that a simultaneous set wins
                if (rd_en && head_flags.br) br_pending_d = 1'b0;
                if (wr_en && in_is_br)      br_pending_d = 1'b1;
            end
        end
    end

    // Control state register with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            br_pending_q <= 1'b0;
        end else begin
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            br_pending_q <= br_pending_d;
        end
    end

    // Entry storage; written at the tail on enqueue, never reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            inst_mem_q[tail_q] <= in_inst;
            pc_mem_q[tail_q]   <= in_pc;
        end
    end

endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: directed stimulus with a scoreboard queue; the driver
// pushes expected decoded entries on accepted enqueues, the monitor pops and
// compares on every dequeue.
module tb_decode_buffer;

    localparam logic [3:0] OP_NOP = 4'd0, OP_LI = 4'd1, OP_ADD = 4'd2,
                           OP_MUL = 4'd3, OP_LD = 4'd4, OP_BR  = 4'd5;
    // {rs1_used, rs2_used, wen, alu, mem, is_br}, hand-written per opcode
    localparam logic [5:0] F_LI  = 6'b001100, F_ADD = 6'b111100,
                           F_MUL = 6'b111100, F_LD  = 6'b101010,
                           F_BR  = 6'b010001, F_NOP = 6'b000000;

    typedef logic [53:0] exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [27:0] in_inst = '0;
    logic [7:0]  in_pc = '0;
    logic        in_ready, out_valid;
    logic [7:0]  out_pc, out_rs1_br_offset;
    logic [3:0]  out_opcode, out_rs1, out_rs2, out_rd;
    logic        out_rs1_used, out_rs2_used, out_wen, out_rd_data_use_alu;
    logic        out_mem_valid, out_is_br;
    logic [15:0] out_rs1_imm;
    logic [2:0]  count;

    exp_t exp_q[$];
    exp_t mon_got, mon_exp;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic last_rdy, last_ov, last_mem;

    always #5 clk = ~clk;

    decode_buffer #(.DEPTH(4), .STOP_AT_BR(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs1_used(out_rs1_used),
        .out_rs2_used(out_rs2_used), .out_wen(out_wen),
        .out_rd_data_use_alu(out_rd_data_use_alu),
        .out_mem_valid(out_mem_valid), .out_is_br(out_is_br),
        .out_rs1_imm(out_rs1_imm), .out_rs1_br_offset(out_rs1_br_offset),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .count(count)
    );

    function automatic logic [27:0] mk(input logic [3:0] op, input logic [3:0] rd,
                                       input logic [3:0] rs2, input logic [15:0] imm);
        return {op, rd, rs2, imm};
    endfunction

    function automatic exp_t mkexp(input logic [7:0] pc, input logic [3:0] op,
                                   input logic [5:0] f, input logic [3:0] rd,
                                   input logic [3:0] rs2, input logic [15:0] imm);
        logic [15:0] i;
        i = imm;
        return {pc, op, f, i, i[7:0], i[3:0], rs2, rd};
    endfunction

    task automatic chk(input string name, input int got, input int req);
        n_cmp++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // One clock cycle of stimulus starting 1 time unit after a rising edge
    task automatic cycle(input logic v, input logic [3:0] op, input logic [3:0] rd,
                         input logic [3:0] rs2, input logic [15:0] imm,
                         input logic [7:0] pc, input logic [5:0] f,
                         input logic ordy, input logic fl);
        in_valid  = v;
        in_inst   = mk(op, rd, rs2, imm);
        in_pc     = pc;
        out_ready = ordy;
        flush     = fl;
        #1;
        last_rdy = in_ready;
        last_ov  = out_valid;
        last_mem = out_mem_valid;
        if (fl) exp_q.delete();
        else if (v && in_ready) exp_q.push_back(mkexp(pc, op, f, rd, rs2, imm));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic idle_deq();
        cycle(1'b0, OP_NOP, 4'd0, 4'd0, 16'd0, 8'd0, F_NOP, 1'b1, 1'b0);
    endtask

    // Monitor: compare every dequeued head against the scoreboard
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            mon_got = {out_pc, out_opcode, out_rs1_used, out_rs2_used, out_wen,
                       out_rd_data_use_alu, out_mem_valid, out_is_br, out_rs1_imm,
                       out_rs1_br_offset, out_rs1, out_rs2, out_rd};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL deq_unexpected: got %h, required no dequeue", mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    n_bad++;
                    $display("FAIL deq_entry: got %h, required %h", mon_got, mon_exp);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_count", count, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        rst = 1'b0;

        // LI rd=3 imm=5 at pc 0, held
        cycle(1'b1, OP_LI, 4'd3, 4'd0, 16'd5, 8'd0, F_LI, 1'b0, 1'b0);
        chk("li_count", count, 1);
        chk("li_out_valid", out_valid, 1);
        chk("li_wen", out_wen, 1);
        chk("li_alu", out_rd_data_use_alu, 1);
        chk("li_rd", out_rd, 3);
        chk("li_imm", out_rs1_imm, 5);
        chk("li_rs1_used", out_rs1_used, 0);
        idle_deq();
        chk("li_drain_count", count, 0);

        // Fill to DEPTH with ADD, MUL, LD, BR
        cycle(1'b1, OP_ADD, 4'd1, 4'd2, 16'h0033, 8'd10, F_ADD, 1'b0, 1'b0);
        cycle(1'b1, OP_MUL, 4'd4, 4'd5, 16'h0106, 8'd11, F_MUL, 1'b0, 1'b0);
        cycle(1'b1, OP_LD,  4'd7, 4'd8, 16'h0A29, 8'd12, F_LD,  1'b0, 1'b0);
        cycle(1'b1, OP_BR,  4'd0, 4'd9, 16'hFFF0, 8'd13, F_BR,  1'b0, 1'b0);
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 0);
        cycle(1'b1, OP_LI, 4'd2, 4'd0, 16'd1, 8'd99, F_LI, 1'b0, 1'b0);
        chk("full_offer_rdy", last_rdy, 0);
        chk("full_hold_count", count, 4);
        for (int i = 0; i < 4; i++) idle_deq();
        chk("full_drain_count", count, 0);

        // Streaming: enqueue and dequeue every cycle across pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, OP_LI, 4'(i), 4'd0, 16'(100 + i), 8'(i), F_LI, 1'b1, 1'b0);
            chk("stream_count_le1", (count <= 3'd1) ? 1 : 0, 1);
        end
        idle_deq();
        chk("stream_end_count", count, 0);
        chk("stream_all_dequeued", exp_q.size(), 0);

        // Flush with three entries held and an instruction offered
        cycle(1'b1, OP_ADD, 4'd1, 4'd1, 16'd1, 8'd30, F_ADD, 1'b0, 1'b0);
        cycle(1'b1, OP_ADD, 4'd2, 4'd2, 16'd2, 8'd31, F_ADD, 1'b0, 1'b0);
        cycle(1'b1, OP_ADD, 4'd3, 4'd3, 16'd3, 8'd32, F_ADD, 1'b0, 1'b0);
        chk("pre_flush_count", count, 3);
        cycle(1'b1, OP_LI, 4'd5, 4'd0, 16'd7, 8'd33, F_LI, 1'b1, 1'b1);
        chk("flush_in_ready", last_rdy, 0);
        chk("flush_out_valid", last_ov, 0);
        chk("post_flush_count", count, 0);
        chk("post_flush_out_valid", out_valid, 0);

        // Branch serialisation
        cycle(1'b1, OP_BR, 4'd0, 4'd6, 16'h0040, 8'd40, F_BR, 1'b0, 1'b0);
        cycle(1'b1, OP_ADD, 4'd1, 4'd2, 16'd3, 8'd41, F_ADD, 1'b0, 1'b0);
        chk("br_block_rdy0", last_rdy, 0);
        cycle(1'b1, OP_ADD, 4'd1, 4'd2, 16'd3, 8'd41, F_ADD, 1'b1, 1'b0);
        chk("br_block_rdy1", last_rdy, 0);
        cycle(1'b1, OP_ADD, 4'd1, 4'd2, 16'd3, 8'd41, F_ADD, 1'b0, 1'b0);
        chk("br_release_rdy", last_rdy, 1);
        chk("br_release_count", count, 1);
        idle_deq();
        chk("br_drain_count", count, 0);

`ifdef DECODE_BUFFER_BYPASS_EN
        // Bypass: empty buffer, LD consumed in the offer cycle
        cycle(1'b1, OP_LD, 4'd2, 4'd0, 16'd8, 8'd50, F_LD, 1'b1, 1'b0);
        chk("byp_out_valid", last_ov, 1);
        chk("byp_mem_valid", last_mem, 1);
        chk("byp_count", count, 0);
`endif

        // Asynchronous reset mid-operation
        cycle(1'b1, OP_LI, 4'd1, 4'd0, 16'd9, 8'd60, F_LI, 1'b0, 1'b0);
        chk("pre_rst_count", count, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", count, 0);
        chk("async_rst_out_valid", out_valid, 0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle(1'b1, OP_LI, 4'd2, 4'd0, 16'd10, 8'd61, F_LI, 1'b0, 1'b0);
        chk("post_rst_first_rdy", last_rdy, 1);
        chk("post_rst_count", count, 1);
        idle_deq();
        chk("final_count", count, 0);
        chk("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/decode_buffer.md
# decode_buffer

Decoupling buffer between fetch and issue. Accepts raw instructions with their PC over a valid/ready handshake and stores them in a circular FIFO of `DEPTH` entries. Presents the head entry fully decoded (operand usage, register indices, immediates, write-back and memory/branch class) to issue over a second valid/ready handshake. Supports a one-cycle pipeline flush and an optional branch-serialising mode for the non-speculative configuration.

## Interface
Parameters:
- `DEPTH`, 4, number of entries; power of two, ≥ 2.
- `STOP_AT_BR`, 0, 1 = accept no new instruction while a branch is held in the buffer.
- `PTR_W`, `$clog2(DEPTH)`, derived pointer width; not overridden.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  fetch offers an instruction.
- `in_ready`  out  1  buffer can accept this cycle.
- `in_inst`  in  `INST_LEN`  raw instruction.
- `in_pc`  in  `MEMI_SIZE_LOG`  instruction address.
- `flush`  in  1  discard all held and offered instructions.
- `out_valid`  out  1  decoded head available.
- `out_ready`  in  1  issue consumes head.
- `out_pc`  out  `MEMI_SIZE_LOG`  head PC.
- `out_opcode`  out  `INST_SIZE_LOG`  `inst`OPCODE`.
- `out_rs1_used`, `out_rs2_used`, `out_wen`, `out_rd_data_use_alu`, `out_mem_valid`, `out_is_br`  out  1 each  decoded class flags.
- `out_rs1_imm`  out  `REG_LEN`  `inst`RS1`.
- `out_rs1_br_offset`  out  `MEMI_SIZE_LOG`  low bits of `out_rs1_imm`.
- `out_rs1`  out  `RF_SIZE_LOG`  low bits of `out_rs1_imm`.
- `out_rs2`, `out_rd`  out  `RF_SIZE_LOG`  `inst`RS2`, `inst`RD`.
- `count`  out  `PTR_W+1`  occupied entries, 0..`DEPTH`.

## Operation
- Decode rules, combinational on the head entry:
  - `rs1_used`: ADD, MUL, LD.
  - `rs2_used`: ADD, MUL, BR.
  - `wen`: LI, ADD, MUL, LD.
  - `rd_data_use_alu`: LI, ADD, MUL.
  - `mem_valid`: LD.
  - `is_br`: BR.
  - Any other opcode: all flags 0; fields still passed through.
- Storage: raw `inst` and `pc` per entry; head pointer, tail pointer and `count` registered.
- Handshakes:
  - Enqueue when `in_valid && in_ready`.
  - Dequeue when `out_valid && out_ready`.
  - `in_ready = !rst && !flush && count<DEPTH && !br_pending`.
  - `out_valid = !flush && count!=0`.
- Simultaneous enqueue and dequeue: `count` unchanged; both pointers advance.
- Full: `in_ready`=0, so there is no full pass-through. Empty: `out_valid`=0, except in bypass (see Configuration).
- Pointers wrap modulo `DEPTH`.
- `flush`: at the next edge, `count`←0, head←tail←0 and `br_pending`←0. The offered instruction is not enqueued, and no dequeue occurs in the flush cycle.
- `br_pending` (only when `STOP_AT_BR`=1, otherwise held at 0):
  - Set on enqueue of a BR that is not dequeued in the same cycle.
  - Cleared on dequeue of a BR entry, or on `flush`.
  - Set and clear in the same cycle: set wins.

## Timing
- Reset values: `count`=0, pointers=0, `br_pending`=0, `out_valid`=0, `in_ready`=0 while `rst` is high. All `out_*` data fields read entry 0.
- `rst` asserted mid-operation clears all state immediately. The first enqueue is possible in the first cycle after deassertion.
- Latency without bypass: an instruction enqueued at edge N is visible on `out_*` after edge N, so it can be dequeued at edge N+1.
- Throughput: one enqueue and one dequeue per cycle.
- `count` reflects the registered occupancy; it excludes the offered instruction.

## Configuration
- Macro `DECODE_BUFFER_BYPASS_EN`.
- Defined:
  - When `count`==0, `!flush` and `in_valid`, then `out_valid`=1 and `out_*` decode `in_inst`/`in_pc` directly, giving zero-cycle latency.
  - If `out_ready` is also 1, the instruction is not written; pointers and `count` are unchanged.
  - Otherwise it is written normally.
  - A BR consumed by bypass never sets `br_pending`.
- Undefined: `out_valid` depends only on registered state, and the minimum latency is 1 cycle.

## Test plan
- Reset, then enqueue `LI rd=3 imm=5` at pc=0 with `out_ready`=0 → next cycle `out_valid`=1, `out_wen`=1, `out_rd_data_use_alu`=1, `out_rd`=3, `out_rs1_imm`=5, `out_rs1_used`=0, `count`=1.
- `DEPTH`=4: enqueue ADD, MUL, LD, BR with `out_ready`=0 → `count`=4 and `in_ready`=0. Dequeue all four → flags ADD{rs1,rs2,wen,alu}, MUL{rs1,rs2,wen,alu}, LD{rs1,wen,mem}, BR{rs2,is_br}, in order; `count`=0.
- Continuous `in_valid`=`out_ready`=1 for 10 cycles at pc 0..9 → `count` steady at ≤1, PCs dequeued in order 0..9, correct across pointer wrap.
- Fill with 3 entries, assert `flush` for one cycle with `in_valid`=1 → that cycle `in_ready`=0 and `out_valid`=0; next cycle `count`=0.
- `STOP_AT_BR`=1: enqueue BR then offer ADD → `in_ready`=0 until BR is dequeued; ADD accepted the cycle after.
- With `DECODE_BUFFER_BYPASS_EN`, empty buffer, `in_valid`=`out_ready`=1 with an LD → `out_mem_valid`=1 in the same cycle, `count` stays 0.
